// File: rtl/vecreg_arbiter.sv
// vecreg_arbiter: owns the N-bit activation register and shares it between
// input (req0) and feedback (req1) requesters, holding each load for at
// least HOLD_CYCLES cycles until the downstream ready handshake releases it.
// Ports: clk, rst (async, active-low), req0_valid/req0_vec/req0_ready,
// req1_valid/req1_vec/req1_ready, vec_q, vec_valid, vec_ready,
// grant_id, busy.
// Option: define VECREG_FIXED_PRIO_EN for fixed req0 priority on ties;
// the default build uses round-robin.
module vecreg_arbiter #(
  parameter int N           = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_vec,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_vec,
  output logic         req1_ready,
  output logic [N-1:0] vec_q,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic         grant_id,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [7:0] CNT_INIT = 8'(HOLD_CYCLES - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       last_q;
  logic       idle;
  logic       pick1;

  assign idle = (state_q == IDLE);

`ifdef VECREG_FIXED_PRIO_EN
  // req0 always wins a tie; last_q is tracked but not consulted.
  assign pick1 = req1_valid & ~req0_valid;
`else
  // On a tie, req1 wins only if req0 took the previous grant.
  assign pick1 = req1_valid & (~req0_valid | ~last_q);
`endif

  // Readys are masked by rst so they read 0 while reset is held.
  assign req0_ready = rst & idle & req0_valid & ~pick1;
  assign req1_ready = rst & idle & pick1;

  assign vec_valid = ~idle;
  assign busy      = ~idle;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      grant_id <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            vec_q    <= pick1 ? req1_vec : req0_vec;
            grant_id <= pick1;
            last_q   <= pick1;
            cnt_q    <= CNT_INIT;
            state_q  <= HOLD;
          end
        end
        HOLD: begin
          // vec_ready is ignored until the minimum hold has elapsed.
          if (cnt_q == 8'd0) begin
            if (vec_ready) state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vecreg_arbiter.md
Name: vecreg_arbiter

Overview:
- Owns the N-bit binary activation register and shares it between two requesters: port 0 for external input activations and port 1 for layer feedback.
- Arbitrates the requesters, loads the winning vector into the register and holds it stable for a minimum number of cycles so the downstream neuron array can consume it.
- Releases the register on a downstream ready handshake.
- Sits between the input/feedback buffers and the binarized neuron layer.

Parameters:
- N, 16, width of the activation vector (bits).
- HOLD_CYCLES, 4, minimum number of cycles vec_q is held valid after a load; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low; all state clears while rst=0.
- req0_valid  input  1  requester 0 has a vector to load.
- req0_vec  input  N  requester 0 vector.
- req0_ready  output  1  requester 0 load accepted this cycle.
- req1_valid  input  1  requester 1 has a vector to load.
- req1_vec  input  N  requester 1 vector.
- req1_ready  output  1  requester 1 load accepted this cycle.
- vec_q  output  N  registered activation vector.
- vec_valid  output  1  vec_q is held and consumable.
- vec_ready  input  1  downstream has finished with vec_q.
- grant_id  output  1  requester whose vector is currently in vec_q.
- busy  output  1  state is not IDLE.

Behaviour:
- FSM states: IDLE, HOLD.
  - IDLE: vec_valid=0, busy=0.
  - HOLD: vec_valid=1, busy=1.
- Reset (rst=0, asynchronous): state=IDLE, vec_q=0, grant_id=0, last_grant=1, hold counter=0.
  - Reset outputs: vec_valid=0, busy=0, req0_ready=0, req1_ready=0.
  - Reset during HOLD aborts immediately; the held vector is lost.
- Arbitration happens only in IDLE and is combinational from the current valid inputs.
  - Only req0 valid: winner 0.
  - Only req1 valid: winner 1.
  - Both valid: round-robin; the winner is the requester not equal to last_grant.
  - After reset, last_grant=1, so req0 wins the first tie.
- reqX_ready=1 only in IDLE, only for the winner, in the same cycle as the winner's valid. Otherwise reqX_ready=0; both readys are 0 throughout HOLD.
- Load at the rising edge where reqX_valid=1 and reqX_ready=1:
  - vec_q <= reqX_vec
  - grant_id <= X
  - last_grant <= X
  - counter <= HOLD_CYCLES-1
  - state <= HOLD
- HOLD:
  - vec_q and grant_id are stable.
  - Counter decrements by 1 per cycle and saturates at 0.
  - Transition to IDLE at the edge where counter==0 and vec_ready=1.
  - vec_ready while counter>0 is ignored; no early release.
  - counter==0 with vec_ready=0: stay in HOLD (stall), vec_valid remains 1.
- vec_q keeps its last value in IDLE; it is not cleared.
- Latency: vec_valid rises 1 cycle after the load handshake.
- Minimum HOLD occupancy is HOLD_CYCLES cycles. Since at least one IDLE cycle separates loads, peak throughput is 1 vector per HOLD_CYCLES+1 cycles.
- HOLD_CYCLES=1: the counter loads 0, and release is possible on the first HOLD cycle.
- Requesters keep valid and vec stable until ready. A valid dropped before grant simply loses arbitration, with no side effect.
- No requester is starved: under continuous dual requests, grants alternate 0,1,0,1...

Optional Feature:
- Macro: VECREG_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins when both are valid; last_grant is still tracked but unused for selection. req1 can starve; this is intended for input-streaming phases.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- Reset with rst=0 mid-HOLD (vec_q=16'hA5A5) -> vec_valid=0, busy=0, both readys 0, vec_q=16'h0000 in the same cycle, without waiting for clk.
- Single load: req0_valid=1, req0_vec=16'h00FF, vec_ready=1 held, HOLD_CYCLES=4 -> req0_ready=1 for one cycle; vec_valid=1 for exactly 4 cycles starting next cycle; vec_q=16'h00FF; grant_id=0.
- Tie after reset: both valid with req0_vec=16'h1111 and req1_vec=16'h2222 held -> loads 16'h1111, then 16'h2222, then 16'h1111; each 5 cycles apart.
- Stall: after load, vec_ready=0 for 10 cycles then 1 -> vec_valid stays 1 for 11 cycles; vec_q unchanged; readys stay 0 throughout.
- Early ready ignored: vec_ready pulsed 1 on HOLD cycle 1 only, then 0 until cycle 6 -> no release before counter reaches 0; exit at the cycle-6 edge.
- VECREG_FIXED_PRIO_EN defined, both valid continuously -> req0_ready granted every load; req1_ready never asserts.
